wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  Write-back stage: consumes the MEM/WB pipeline register fields, selects the
//  GPR write-back value by rd_sel, and owns the architectural HI/LO registers.
//  Drives the register-file write port, HI/LO forwarding values for ID/EX, and
//  a retired-instruction counter. Sits between the MEM/WB register and regfile.
// PARAMETERS
//  DATA_W  32  datapath width (all data ports)
//  CNT_W   32  width of retire_cnt
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       synchronous reset, active-high
//  ena         in   1       WB slot valid; 0 = bubble/stall, no state change, no rf write
//  npc         in   DATA_W  link value (JAL/JALR/BGEZAL)
//  rs_data     in   DATA_W  rs operand (MTHI/MTLO source)
//  rd_sel      in   3       GPR write source select
//  rd_waddr    in   5       GPR write address
//  rd_wena     in   1       GPR write request
//  hi_data     in   DATA_W  carried HI value (hi_sel=3)
//  lo_data     in   DATA_W  carried LO value (lo_sel=3)
//  hi_wena     in   1       HI write request
//  lo_wena     in   1       LO write request
//  hi_sel      in   2       HI source select
//  lo_sel      in   2       LO source select
//  cp0_data    in   DATA_W  MFC0 result
//  alu_data, clz_data, mul_hi, mul_lo, div_r, div_q, dmem_data  in  DATA_W  unit results
//  rf_wena     out  1       regfile write enable
//  rf_waddr    out  5       regfile write address
//  rf_wdata    out  DATA_W  regfile write data
//  hi_q, lo_q  out  DATA_W  architectural HI/LO (registered)
//  hi_fwd      out  DATA_W  HI as seen after this WB instruction (bypass to ID/EX)
//  lo_fwd      out  DATA_W  LO bypass, same rule
//  retire_cnt  out  CNT_W   count of cycles with ena=1
// BEHAVIOUR
//  - One clock, rst synchronous active-high; rst overrides ena.
//  - Reset: hi_q=0, lo_q=0, retire_cnt=0; combinational outputs follow (rf_wena=0 iff inputs say so).
//  - rd_sel: 0 alu_data, 1 dmem_data, 2 npc, 3 clz_data, 4 hi_q, 5 lo_q, 6 mul_lo, 7 cp0_data.
//  - hi_sel: 0 rs_data, 1 mul_hi, 2 div_r, 3 hi_data. lo_sel: 0 rs_data, 1 mul_lo, 2 div_q, 3 lo_data.
//  - rf_wena = ena & rd_wena & (rd_waddr!=0); rf_waddr=rd_waddr; rf_wdata=mux; zero latency (comb).
//  - hi_q <= hi_next at posedge when ena & hi_wena; else hold. Same for lo_q.
//  - hi_fwd = (ena & hi_wena) ? hi_next : hi_q; lo_fwd likewise (comb).
//  - rd_sel=4/5 reads pre-update hi_q/lo_q even if same instruction writes HI/LO.
//  - retire_cnt += 1 per posedge with ena=1; wraps 2^CNT_W-1 -> 0 silently.
//  - ena=0: rf_wena=0, hi_fwd=hi_q, lo_fwd=lo_q, no register changes regardless of other inputs.
//  - rst asserted mid-stream: next edge clears HI/LO/counter; pending write discarded.
// STRUCTURE
//  - Shared package: RD_SEL_* (3-bit) and HILO_SEL_* (2-bit) encodings, also used by decoder.
//  - Sub-module: hilo_reg (one instance each for HI and LO: sel mux, wena, sync reset, fwd).
//  - GPR mux and retire counter inline.
// TESTING
//  1. rst=1 two cycles -> hi_q=lo_q=0, retire_cnt=0; rst during ena=1 HI write -> hi_q stays 0.
//  2. ena=1,rd_sel=0,alu=0x1234,waddr=5,wena=1 -> rf_wena=1,rf_wdata=0x1234 same cycle; waddr=0 -> rf_wena=0.
//  3. DIV: hi_sel=2,lo_sel=2,div_r=7,div_q=3,both wena -> hi_fwd=7,lo_fwd=3 comb; hi_q=7,lo_q=3 next cycle.
//  4. MTHI rs=0xA then MFHI (rd_sel=4) next cycle -> rf_wdata=0xA; same-cycle rd_sel=4 & hi_wena -> old hi_q.
//  5. ena=0 with hi_wena=1,rd_wena=1 -> rf_wena=0, hi_q unchanged, retire_cnt unchanged.
//  6. CNT_W=4: 17 ena cycles from reset -> retire_cnt=1 (wrap).

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: GPR write source select and
// HI/LO source select. The decoder uses the same constants.
package wb_stage_pkg;

  typedef enum logic [2:0] {
    RD_SEL_ALU    = 3'd0,
    RD_SEL_DMEM   = 3'd1,
    RD_SEL_NPC    = 3'd2,
    RD_SEL_CLZ    = 3'd3,
    RD_SEL_HI     = 3'd4,
    RD_SEL_LO     = 3'd5,
    RD_SEL_MUL_LO = 3'd6,
    RD_SEL_CP0    = 3'd7
  } rd_sel_e;

  typedef enum logic [1:0] {
    HILO_SEL_RS    = 2'd0,
    HILO_SEL_MUL   = 2'd1,
    HILO_SEL_DIV   = 2'd2,
    HILO_SEL_CARRY = 2'd3
  } hilo_sel_e;

endpackage

// File: rtl/wb_stage_hilo_reg.sv
// One architectural HI or LO register: source mux, gated write, sync reset,
// and a bypass output showing the value after the current WB instruction.
module hilo_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wena,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] mul_data,
  input  logic [DATA_W-1:0] div_data,
  input  logic [DATA_W-1:0] carry_data,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] fwd
);
  import wb_stage_pkg::*;

  logic [DATA_W-1:0] val_q;
  logic [DATA_W-1:0] val_d;
  logic [DATA_W-1:0] src_sel;

  always_comb begin
    src_sel = carry_data;
    case (hilo_sel_e'(sel))
      HILO_SEL_RS:    src_sel = rs_data;
      HILO_SEL_MUL:   src_sel = mul_data;
      HILO_SEL_DIV:   src_sel = div_data;
      HILO_SEL_CARRY: src_sel = carry_data;
      default:        src_sel = carry_data;
    endcase
  end

  // The next-state value doubles as the bypass: it already reflects this write.
  assign val_d = (ena & wena) ? src_sel : val_q;

  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign q   = val_q;
  assign fwd = val_d;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the GPR write-back value, owns HI/LO and counts
// retired instructions (cycles with a valid WB slot).
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [2:0]        rd_sel,
  input  logic [4:0]        rd_waddr,
  input  logic              rd_wena,
  input  logic [DATA_W-1:0] hi_data,
  input  logic [DATA_W-1:0] lo_data,
  input  logic              hi_wena,
  input  logic              lo_wena,
  input  logic [1:0]        hi_sel,
  input  logic [1:0]        lo_sel,
  input  logic [DATA_W-1:0] cp0_data,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] clz_data,
  input  logic [DATA_W-1:0] mul_hi,
  input  logic [DATA_W-1:0] mul_lo,
  input  logic [DATA_W-1:0] div_r,
  input  logic [DATA_W-1:0] div_q,
  input  logic [DATA_W-1:0] dmem_data,
  output logic              rf_wena,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic [DATA_W-1:0] hi_fwd,
  output logic [DATA_W-1:0] lo_fwd,
  output logic [CNT_W-1:0]  retire_cnt
);
  import wb_stage_pkg::*;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  hilo_reg #(.DATA_W(DATA_W)) u_hi (
    .clk(clk), .rst(rst), .ena(ena), .wena(hi_wena), .sel(hi_sel),
    .rs_data(rs_data), .mul_data(mul_hi), .div_data(div_r), .carry_data(hi_data),
    .q(hi_q), .fwd(hi_fwd)
  );

  hilo_reg #(.DATA_W(DATA_W)) u_lo (
    .clk(clk), .rst(rst), .ena(ena), .wena(lo_wena), .sel(lo_sel),
    .rs_data(rs_data), .mul_data(mul_lo), .div_data(div_q), .carry_data(lo_data),
    .q(lo_q), .fwd(lo_fwd)
  );

  // MFHI/MFLO read the registered value, never the same-cycle bypass.
  always_comb begin
    rf_wdata = alu_data;
    case (rd_sel_e'(rd_sel))
      RD_SEL_ALU:    rf_wdata = alu_data;
      RD_SEL_DMEM:   rf_wdata = dmem_data;
      RD_SEL_NPC:    rf_wdata = npc;
      RD_SEL_CLZ:    rf_wdata = clz_data;
      RD_SEL_HI:     rf_wdata = hi_q;
      RD_SEL_LO:     rf_wdata = lo_q;
      RD_SEL_MUL_LO: rf_wdata = mul_lo;
      RD_SEL_CP0:    rf_wdata = cp0_data;
      default:       rf_wdata = alu_data;
    endcase
  end

  assign rf_wena  = ena & rd_wena & (rd_waddr != 5'd0);
  assign rf_waddr = rd_waddr;

  assign cnt_d = ena ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;

endmodule
